// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Opcode, immediate, ALU-op and result-select encodings plus the
//            control bundle shared by the decoder and its pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ctrl_pkg;

  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_STORE = 7'd35;
  localparam logic [6:0] OP_R     = 7'd51;
  localparam logic [6:0] OP_BR    = 7'd99;
  localparam logic [6:0] OP_I     = 7'd19;
  localparam logic [6:0] OP_JAL   = 7'd111;
  localparam logic [6:0] OP_JALR  = 7'd103;
  localparam logic [6:0] OP_LUI   = 7'd55;
  localparam logic [6:0] OP_AUIPC = 7'd23;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src;
    logic       alu_a_pc;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_bundle_t;

endpackage

`default_nettype wire

// File: rtl/control_main_decoder_ext.sv
// ============================================================================
// Module   : control_main_decoder_ext
// Brief    : Combinational main decoder with parameter-gated JALR/AUIPC.
// Revision : 1.0
// ============================================================================
`default_nettype none

module control_main_decoder_ext
  import ctrl_pkg::*;
#(
  parameter bit SUPPORT_JALR  = 1'b1,
  parameter bit SUPPORT_AUIPC = 1'b1,
  parameter int IMM_SRC_W     = 3
) (
  input  logic                 instr_valid,
  input  logic [6:0]           opcode,
  output ctrl_bundle_t         ctrl,
  output logic [IMM_SRC_W-1:0] imm_src,
  output logic                 illegal
);

  ctrl_bundle_t w_ctrl;
  logic [2:0]   w_imm;
  logic         w_known;

  always_comb begin
    w_ctrl  = '0;
    w_imm   = IMM_I;
    w_known = 1'b1;
    case (opcode)
      OP_LOAD: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.result_src = RES_MEM;
      end
      OP_STORE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_imm            = IMM_S;
      end
      OP_R: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_BR: begin
        w_ctrl.branch = 1'b1;
        w_ctrl.alu_op = ALUOP_SUB;
        w_imm         = IMM_B;
      end
      OP_I: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_JAL: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.jump       = 1'b1;
        w_ctrl.result_src = RES_PC4;
        w_imm             = IMM_J;
      end
      OP_LUI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = ALUOP_PASSB;
        w_imm            = IMM_U;
      end
      OP_JALR: begin
        if (SUPPORT_JALR) begin
          w_ctrl.reg_write  = 1'b1;
          w_ctrl.alu_src    = 1'b1;
          w_ctrl.alu_op     = ALUOP_FUNCT;
          w_ctrl.jump       = 1'b1;
          w_ctrl.jalr       = 1'b1;
          w_ctrl.result_src = RES_PC4;
        end else begin
          w_known = 1'b0;
        end
      end
      OP_AUIPC: begin
        if (SUPPORT_AUIPC) begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_src   = 1'b1;
          w_ctrl.alu_a_pc  = 1'b1;
          w_ctrl.alu_op    = ALUOP_ADD;
          w_imm            = IMM_U;
        end else begin
          w_known = 1'b0;
        end
      end
      default: w_known = 1'b0;
    endcase
  end

  // Bubbles and unknown opcodes collapse to an all-zero bundle
  always_comb begin
    ctrl    = '0;
    imm_src = '0;
    if (instr_valid && w_known) begin
      ctrl         = w_ctrl;
      imm_src[2:0] = w_imm;
    end
  end

  assign illegal = instr_valid & ~w_known;

endmodule

`default_nettype wire

// File: rtl/control_pipe_decoder.sv
// ============================================================================
// Module   : control_pipe_decoder
// Brief    : Decode-stage control plus ID/EX, EX/MEM, MEM/WB control registers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module control_pipe_decoder
  import ctrl_pkg::*;
#(
  parameter bit SUPPORT_JALR  = 1'b1,
  parameter bit SUPPORT_AUIPC = 1'b1,
  parameter int IMM_SRC_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid_d,
  input  logic [6:0]           opcode_d,
  input  logic [2:0]           funct3_d,
  input  logic                 stall_e,
  input  logic                 flush_e,
  output logic [IMM_SRC_W-1:0] imm_src_d,
  output logic                 illegal_d,
  output logic                 branch_e,
  output logic                 jump_e,
  output logic                 jalr_e,
  output logic                 alu_src_e,
  output logic                 alu_a_pc_e,
  output logic [1:0]           alu_op_e,
  output logic [2:0]           funct3_e,
  output logic [1:0]           result_src_e,
  output logic                 reg_write_m,
  output logic                 mem_write_m,
  output logic [1:0]           result_src_m,
  output logic                 reg_write_w,
  output logic [1:0]           result_src_w,
  output logic                 illegal_sticky
);

  ctrl_bundle_t w_ctrl_d;
  logic [2:0]   w_funct3_d;

  ctrl_bundle_t r_ctrl_e;
  logic [2:0]   r_funct3_e;
  logic         r_reg_write_m;
  logic         r_mem_write_m;
  logic [1:0]   r_result_src_m;
  logic         r_reg_write_w;
  logic [1:0]   r_result_src_w;
  logic         r_illegal_sticky;

  control_main_decoder_ext #(
    .SUPPORT_JALR (SUPPORT_JALR),
    .SUPPORT_AUIPC(SUPPORT_AUIPC),
    .IMM_SRC_W    (IMM_SRC_W)
  ) u_dec (
    .instr_valid(instr_valid_d),
    .opcode     (opcode_d),
    .ctrl       (w_ctrl_d),
    .imm_src    (imm_src_d),
    .illegal    (illegal_d)
  );

  assign w_funct3_d = (instr_valid_d && !illegal_d) ? funct3_d : 3'b000;

  // A stalled E instruction stays put, so EX/MEM takes a bubble to avoid duplicating it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl_e         <= '0;
      r_funct3_e       <= '0;
      r_reg_write_m    <= 1'b0;
      r_mem_write_m    <= 1'b0;
      r_result_src_m   <= '0;
      r_reg_write_w    <= 1'b0;
      r_result_src_w   <= '0;
      r_illegal_sticky <= 1'b0;
    end else begin
      if (flush_e) begin
        r_ctrl_e   <= '0;
        r_funct3_e <= '0;
      end else if (!stall_e) begin
        r_ctrl_e   <= w_ctrl_d;
        r_funct3_e <= w_funct3_d;
      end
      r_reg_write_m    <= stall_e ? 1'b0 : r_ctrl_e.reg_write;
      r_mem_write_m    <= stall_e ? 1'b0 : r_ctrl_e.mem_write;
      r_result_src_m   <= stall_e ? RES_ALU : r_ctrl_e.result_src;
      r_reg_write_w    <= r_reg_write_m;
      r_result_src_w   <= r_result_src_m;
      r_illegal_sticky <= r_illegal_sticky | illegal_d;
    end
  end

  assign branch_e       = r_ctrl_e.branch;
  assign jump_e         = r_ctrl_e.jump;
  assign jalr_e         = r_ctrl_e.jalr;
  assign alu_src_e      = r_ctrl_e.alu_src;
  assign alu_a_pc_e     = r_ctrl_e.alu_a_pc;
  assign alu_op_e       = r_ctrl_e.alu_op;
  assign result_src_e   = r_ctrl_e.result_src;
  assign funct3_e       = r_funct3_e;
  assign reg_write_m    = r_reg_write_m;
  assign mem_write_m    = r_mem_write_m;
  assign result_src_m   = r_result_src_m;
  assign reg_write_w    = r_reg_write_w;
  assign result_src_w   = r_result_src_w;
  assign illegal_sticky = r_illegal_sticky;

endmodule

`default_nettype wire

// File: tb/tb_control_pipe_decoder.sv
// ============================================================================
// Module   : tb_control_pipe_decoder
// Brief    : Scoreboard bench; instance 0 full ISA, instance 1 without JALR/AUIPC.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_control_pipe_decoder;

  typedef struct packed {
    logic       rw, mw, br, j, jr, as, apc;
    logic [1:0] aop, rs;
    logic [2:0] f3;
  } bnd_t;

  typedef struct packed {
    bnd_t e, m, w;
    logic st;
  } stage_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid_d;
  logic [6:0] opcode_d;
  logic [2:0] funct3_d;
  logic       stall_e, flush_e;

  logic [2:0] imm_d [2];
  logic       ill_d [2];
  logic       br_e [2], j_e [2], jr_e [2], as_e [2], apc_e [2];
  logic [1:0] aop_e [2], rs_e [2], rs_m [2], rs_w [2];
  logic [2:0] f3_e [2];
  logic       rw_m [2], mw_m [2], rw_w [2], sticky [2];

  int n_checks = 0;
  int n_fail   = 0;

  stage_t q[$];
  stage_t mdl [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    control_pipe_decoder #(
      .SUPPORT_JALR (k == 0),
      .SUPPORT_AUIPC(k == 0),
      .IMM_SRC_W    (3)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr_valid_d (instr_valid_d),
      .opcode_d      (opcode_d),
      .funct3_d      (funct3_d),
      .stall_e       (stall_e),
      .flush_e       (flush_e),
      .imm_src_d     (imm_d[k]),
      .illegal_d     (ill_d[k]),
      .branch_e      (br_e[k]),
      .jump_e        (j_e[k]),
      .jalr_e        (jr_e[k]),
      .alu_src_e     (as_e[k]),
      .alu_a_pc_e    (apc_e[k]),
      .alu_op_e      (aop_e[k]),
      .funct3_e      (f3_e[k]),
      .result_src_e  (rs_e[k]),
      .reg_write_m   (rw_m[k]),
      .mem_write_m   (mw_m[k]),
      .result_src_m  (rs_m[k]),
      .reg_write_w   (rw_w[k]),
      .result_src_w  (rs_w[k]),
      .illegal_sticky(sticky[k])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference decode table written from the opcode list, independent of the RTL package
  function automatic bnd_t ref_dec(input logic v, input logic [6:0] op, input logic [2:0] f3,
                                   input bit full, output logic [2:0] imm, output logic ill);
    logic [10:0] c;
    logic        known;
    known = 1'b1;
    imm   = 3'd0;
    c     = '0;
    case (op)
      7'd3:   c = 11'b1_0_0_0_0_1_0_00_01;
      7'd35:  begin c = 11'b0_1_0_0_0_1_0_00_00; imm = 3'd1; end
      7'd51:  c = 11'b1_0_0_0_0_0_0_10_00;
      7'd99:  begin c = 11'b0_0_1_0_0_0_0_01_00; imm = 3'd2; end
      7'd19:  c = 11'b1_0_0_0_0_1_0_10_00;
      7'd111: begin c = 11'b1_0_0_1_0_0_0_00_10; imm = 3'd3; end
      7'd55:  begin c = 11'b1_0_0_0_0_1_0_11_00; imm = 3'd4; end
      7'd103: if (full) c = 11'b1_0_0_1_1_1_0_10_10; else known = 1'b0;
      7'd23:  if (full) begin c = 11'b1_0_0_0_0_1_1_00_00; imm = 3'd4; end else known = 1'b0;
      default: known = 1'b0;
    endcase
    ill = v & ~known;
    if (!(v && known)) begin
      imm = 3'd0;
      return '0;
    end
    return {c, f3};
  endfunction

  task automatic check_outputs(input int k, input stage_t s, input string tag);
    chk({tag, "_e"}, {br_e[k], j_e[k], jr_e[k], as_e[k], apc_e[k], aop_e[k], rs_e[k], f3_e[k]},
        {s.e.br, s.e.j, s.e.jr, s.e.as, s.e.apc, s.e.aop, s.e.rs, s.e.f3});
    chk({tag, "_m"}, {rw_m[k], mw_m[k], rs_m[k]}, {s.m.rw, s.m.mw, s.m.rs});
    chk({tag, "_w"}, {rw_w[k], rs_w[k]}, {s.w.rw, s.w.rs});
    chk({tag, "_sticky"}, sticky[k], s.st);
  endtask

  task automatic step(input logic v, input logic [6:0] op, input logic [2:0] f3,
                      input logic st, input logic fl);
    bnd_t       d;
    logic [2:0] imm;
    logic       ill;
    stage_t     nx;
    @(negedge clk);
    instr_valid_d = v;
    opcode_d      = op;
    funct3_d      = f3;
    stall_e       = st;
    flush_e       = fl;
    #1;
    for (int k = 0; k < 2; k++) begin
      d = ref_dec(v, op, f3, (k == 0), imm, ill);
      chk($sformatf("imm_d%0d op%0d", k, op), imm_d[k], imm);
      chk($sformatf("ill_d%0d op%0d", k, op), ill_d[k], ill);
      nx.e  = fl ? '0 : (st ? mdl[k].e : d);
      nx.m  = st ? '0 : mdl[k].e;
      nx.w  = mdl[k].m;
      nx.st = mdl[k].st | ill;
      q.push_back(nx);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      mdl[k] = q.pop_front();
      check_outputs(k, mdl[k], $sformatf("u%0d op%0d", k, op));
    end
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 7'd0, 3'd0, 1'b0, 1'b0);
  endtask

  logic [6:0] ops [11] = '{7'd3, 7'd35, 7'd51, 7'd99, 7'd19, 7'd111, 7'd55, 7'd103, 7'd23, 7'd127, 7'd0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    instr_valid_d = 1'b0; opcode_d = '0; funct3_d = '0; stall_e = 1'b0; flush_e = 1'b0;
    mdl[0] = '0;
    mdl[1] = '0;
    #12;
    for (int k = 0; k < 2; k++) check_outputs(k, '0, $sformatf("reset%0d", k));
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 7'd3, 3'd2, 1'b0, 1'b0);           // load through E/M/W
    bubbles(3);
    step(1'b1, 7'd35, 3'd2, 1'b0, 1'b1);          // store flushed on entry
    bubbles(3);
    step(1'b1, 7'd51, 3'd5, 1'b0, 1'b0);          // R-type then 2-cycle stall
    step(1'b1, 7'd99, 3'd1, 1'b1, 1'b0);
    step(1'b1, 7'd99, 3'd1, 1'b1, 1'b0);
    step(1'b1, 7'd99, 3'd1, 1'b0, 1'b0);
    bubbles(2);
    step(1'b1, 7'd99, 3'd0, 1'b1, 1'b1);          // flush beats stall
    step(1'b1, 7'd127, 3'd0, 1'b0, 1'b0);         // illegal opcode
    step(1'b0, 7'd127, 3'd0, 1'b0, 1'b0);
    step(1'b1, 7'd103, 3'd0, 1'b0, 1'b0);         // jalr / auipc per instance
    step(1'b1, 7'd23, 3'd0, 1'b0, 1'b0);
    step(1'b1, 7'd111, 3'd0, 1'b0, 1'b0);
    step(1'b1, 7'd55, 3'd0, 1'b0, 1'b0);
    step(1'b1, 7'd19, 3'd7, 1'b0, 1'b0);
    bubbles(3);

    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 10)], 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));

    // Reset mid-stream while a register write sits in M
    step(1'b1, 7'd51, 3'd0, 1'b0, 1'b0);
    step(1'b0, 7'd0, 3'd0, 1'b0, 1'b0);
    chk("pre_reset_rw_m", rw_m[0], 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_rw_m", rw_m[0], 1'b0);
    for (int k = 0; k < 2; k++) begin
      mdl[k] = '0;
      check_outputs(k, '0, $sformatf("midreset%0d", k));
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 7'd3, 3'd0, 1'b0, 1'b0);
    bubbles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
